// File: rtl/seg_scan_driver.sv
// Scans DIGITS packed seven-segment patterns onto one shared segment bus with
// per-digit active-low anodes, a per-frame input snapshot and per-slot dead-time.
// Optional brightness control is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_driver #(
  parameter int DIGITS       = 6,
  parameter int REFRESH_DIV  = 1666,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DIGITS-1:0]   seg_in,
  input  logic                  blank,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [2:0]            bright,
`endif
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [2:0]          idx;
  logic [8*DIGITS-1:0] shadow;
  logic                load_pending;
  logic                slot_end;
  logic                frame_end;
  logic                snap;
  logic                lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign snap      = load_pending || frame_end;

  // Slot counter, digit index and the per-frame snapshot of seg_in.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      // NOTE: shadow is explicitly reset to all-ones (segments off) so the
      // first slot after reset can never show stale data from a prior run.
      shadow       <= '1;
      load_pending <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      cnt          <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      frame_tick   <= snap;
      load_pending <= 1'b0;
      if (snap)
        shadow <= seg_in;
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [31:0] lit_end;
  always_comb begin
    lit_end = 32'(BLANK_CYCLES)
            + ((32'(bright) + 32'd1) * 32'(REFRESH_DIV - BLANK_CYCLES)) / 32'd8;
  end
`endif

  // Lit only after the dead-time at the start of each slot and while not blanked.
  // NOTE: every always_comb output gets a default assignment first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    lit = !blank && (32'(cnt) >= 32'(BLANK_CYCLES));
`ifdef SEG_SCAN_BRIGHTNESS_EN
    lit = lit && (32'(cnt) < lit_end);
`endif
  end

  // Registered display outputs: one cycle behind cnt/idx/shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      an        <= '1;
      seg       <= 8'hFF;
      digit_idx <= '0;
    end else begin
      an        <= lit ? ~(DIGITS'(1) << idx) : '1;
      seg       <= lit ? shadow[8*idx +: 8] : 8'hFF;
      digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=6, REFRESH_DIV=4, BLANK_CYCLES=1):
// directed scenarios followed by randomized cycles against a time-indexed reference model.
module tb_seg_scan_driver;

  localparam int DIGITS = 6;
  localparam int RD     = 4;
  localparam int BC     = 1;
  localparam int FRAME  = DIGITS * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        blank;
  logic [47:0] seg_in;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  seg_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  int          n      = 0;   // non-reset edges completed since the last reset
  int          cyc    = 0;
  int          last_tick = 0;
  int          tick_cnt  = 0;
  logic [47:0] m_shadow  = '1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock: predict outputs from the elapsed-time position, then compare.
  task automatic step();
    int         cnt_m;
    int         idx_m;
    bit         lit_m;
    bit         tick_m;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    logic [2:0] exp_idx;
    @(posedge clk);
    cyc++;
    if (rst) begin
      n        = 0;
      m_shadow = '1;
      tick_cnt = 0;
      exp_an   = '1;
      exp_seg  = 8'hFF;
      exp_idx  = 3'd0;
      tick_m   = 1'b0;
    end else begin
      cnt_m   = n % RD;
      idx_m   = (n / RD) % DIGITS;
      tick_m  = (n == 0) || (n % FRAME == FRAME - 1);
      lit_m   = !blank && (cnt_m >= BC);
      exp_an  = lit_m ? ~(6'b1 << idx_m) : 6'h3F;
      exp_seg = lit_m ? m_shadow[8*idx_m +: 8] : 8'hFF;
      exp_idx = 3'(idx_m);
      if (tick_m) m_shadow = seg_in;
      n++;
    end
    #1;
    check("an", 64'(an), 64'(exp_an));
    check("seg", 64'(seg), 64'(exp_seg));
    check("digit_idx", 64'(digit_idx), 64'(exp_idx));
    check("frame_tick", 64'(frame_tick), 64'(tick_m));
    check("an_one_low", 64'($countones(~an) <= 1), 64'd1);
    if (frame_tick) begin
      tick_cnt++;
      if (tick_cnt >= 3) check("tick_period", 64'(cyc - last_tick), 64'(FRAME));
      last_tick = cyc;
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    rst    = 1'b1;
    blank  = 1'b0;
    seg_in = '0;
    repeat (3) step();

    // Reset release: immediate snapshot, dark first cycle, then digit 0.
    rst    = 1'b0;
    seg_in = 48'h0102_0304_0506;
    step();
    check("first_tick", 64'(frame_tick), 64'd1);
    check("first_dark", 64'(an), 64'h3F);
    step();
    check("d0_seg", 64'(seg), 64'h06);
    check("d0_an", 64'(an), 64'h3E);
    run_to(22);
    check("d5_seg", 64'(seg), 64'h01);
    check("d5_an", 64'(an), 64'h1F);

    // Mid-frame change during digit 2 of the second frame: no tearing.
    run_to(34);
    seg_in = 48'hA1A2_A3A4_A5A6;
    run_to(38);
    check("no_tear_d3", 64'(seg), 64'h03);
    run_to(48);
    check("wrap_tick", 64'(frame_tick), 64'd1);
    run_to(50);
    check("new_d0", 64'(seg), 64'hA6);

    // Blank for 10 cycles; lit digit returns on the first edge after release.
    run_to(59);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("blank_an", 64'(an), 64'h3F);
      check("blank_seg", 64'(seg), 64'hFF);
    end
    blank = 1'b0;
    step();
    check("unblank_seg", 64'(seg), 64'hA1);
    check("unblank_an", 64'(an), 64'h1F);

    // Reset pulse while digit 4 is lit.
    run_to(90);
    check("pre_rst_idx", 64'(digit_idx), 64'd4);
    rst = 1'b1;
    step();
    check("rst_an", 64'(an), 64'h3F);
    check("rst_seg", 64'(seg), 64'hFF);
    check("rst_idx", 64'(digit_idx), 64'd0);
    rst    = 1'b0;
    seg_in = 48'h1112_1314_1516;
    step();
    check("rst_reload_tick", 64'(frame_tick), 64'd1);
    step();
    check("rst_reload_d0", 64'(seg), 64'h16);

    // Randomized run with occasional blanking, input changes and resets.
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      blank = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) seg_in = {$urandom(), $urandom()};
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumer end of the 48-bit packed seven-segment bus produced by the stopwatch/clock display blocks: six 8-bit segment patterns, digit 0 in bits [7:0].
- Time-multiplexes the six patterns onto one shared segment bus plus per-digit anode enables for the board's common-anode display.
- Snapshots the input bus once per frame, so a digit never changes mid-frame (no tearing).
- Inserts dead-time between digits to suppress ghosting.

Parameters:
- DIGITS, 6, number of digits scanned; the input bus is 8*DIGITS bits.
- REFRESH_DIV, 1666, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  8*DIGITS  packed segment patterns; digit k in [8k+7:8k]; active-low segments, passed through unmodified.
- blank  input  1  when 1, the display is dark (anodes off, segments off); scanning continues.
- an  output  DIGITS  anode enables, active-low; an[k] drives digit k.
- seg  output  8  shared segment bus, active-low.
- digit_idx  output  3  index of the digit in the current slot (debug/visibility).
- frame_tick  output  1  one-cycle pulse when a new snapshot of seg_in is taken.

Behaviour:
- Reset (rst=1 at a clock edge):
  - cnt=0, idx=0.
  - shadow = all 1s.
  - an = all 1s, seg = 8'hFF, digit_idx = 0, frame_tick = 0.
  - load_pending = 1.
- Slot counter, each non-reset cycle:
  - If cnt == REFRESH_DIV-1: cnt <= 0, and idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Otherwise cnt <= cnt+1.
- Snapshot: shadow <= seg_in and frame_tick <= 1 when either condition holds:
  - load_pending = 1 (first non-reset cycle); this also clears load_pending.
  - cnt == REFRESH_DIV-1 and idx == DIGITS-1 (frame wrap).
  - frame_tick is 0 on every other cycle.
  - seg_in changes between snapshots have no visible effect.
- Output register (one-cycle latency from cnt/idx/shadow):
  - Dark condition: blank = 1 or cnt < BLANK_CYCLES.
  - When dark: an <= all 1s, seg <= 8'hFF.
  - Otherwise: an <= all 1s except bit idx = 0; seg <= shadow[8*idx +: 8].
  - digit_idx <= idx.
- At most one an bit is 0 on any cycle.
- The lit window per slot is REFRESH_DIV - BLANK_CYCLES cycles.
- The frame period is DIGITS*REFRESH_DIV cycles.
- blank is sampled every cycle. Asserting it mid-slot darkens the outputs on the next edge, with no effect on cnt, idx or shadow.
- Reset mid-slot or mid-frame: everything returns to reset values, and the next frame starts at digit 0 with a fresh snapshot.
- Simultaneous snapshot and slot wrap: the new shadow value is used for digit 0 of the next frame.

Optional Feature:
- Macro: SEG_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input bright[2:0].
  - The lit window in each slot is further limited to cnt < BLANK_CYCLES + ((bright+1) * (REFRESH_DIV-BLANK_CYCLES)) / 8, computed with integer division.
  - Outside that window the outputs are dark as for blanking.
  - bright = 7 gives full brightness; bright = 0 gives 1/8 duty.
  - bright is sampled every cycle.
- When undefined: there is no bright port and behaviour is exactly as above.

Test Plan (all with REFRESH_DIV=4, BLANK_CYCLES=1, DIGITS=6):
- Reset release, then seg_in = 48'h0102_0304_0506 → frame_tick on the first non-reset cycle. Over 24 cycles, each digit k is lit for 3 cycles with an = ~(1<<k) and the expected byte: digit 0 = 8'h06, digit 5 = 8'h01. an = 6'h3F in each slot's first cycle after the one-cycle latency.
- Change seg_in mid-frame (during digit 2) → displayed bytes unchanged until the next frame_tick, exactly 24 cycles after the previous one; the new value is shown from digit 0.
- blank=1 for 10 cycles mid-frame → an = 6'h3F, seg = 8'hFF throughout; digit_idx keeps advancing; correct digit restored the cycle after blank falls.
- rst pulsed while digit 4 is lit → next edge an = 6'h3F, seg = 8'hFF, digit_idx = 0, shadow reloads on the first cycle after release.
- Checker over 2000 random cycles → never more than one an bit low; frame_tick period always 24 cycles between resets.
- With SEG_SCAN_BRIGHTNESS_EN, REFRESH_DIV=17, BLANK_CYCLES=1, bright=3 → each slot lit exactly 8 cycles (cnt 1..8); bright=7 → 16 cycles.
